// File: rtl/crossbar_nxn_rr_if.sv
// Bundled input/output channel signals of the N x N round-robin crossbar.
// The master side drives words and consumes outputs; the slave side is the crossbar.
interface crossbar_nxn_rr_if #(
  parameter int N     = 4,
  parameter int WIDTH = 4
);
  localparam int DW = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N*DW-1:0]    in_dest;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;

  modport master (
    output in_data, in_dest, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_dest, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/crossbar_nxn_rr.sv
// N x N registered crossbar: each output arbitrates round-robin over the inputs
// addressing it and captures the winner in a one-entry valid/ready output register.
module crossbar_nxn_rr #(
  parameter int N     = 4,
  parameter int WIDTH = 4
) (
  input logic              clk,
  input logic              rst,
  crossbar_nxn_rr_if.slave bus
);
  localparam int DW = $clog2(N);

  // Row o holds output o's one-hot grant over the inputs.
  logic [N-1:0] gnt_mat [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_out
    logic [DW-1:0]    ptr_reg;
    logic [DW-1:0]    ptr_next;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_next;
    logic             valid_reg;
    logic             valid_next;
    logic [N-1:0]     req;
    logic [N-1:0]     gnt_oh;
    logic [DW-1:0]    gnt_idx;
    logic [DW-1:0]    idx;
    logic             gnt_vld;
    logic             ld;

    assign ld = !valid_reg || bus.out_ready[gi];

    always_comb begin
      req = '0;
      for (int i = 0; i < N; i++) begin
        req[i] = bus.in_valid[i] && (bus.in_dest[i*DW +: DW] == DW'(gi));
      end
    end

    // Search upward from the pointer; DW-bit addition wraps modulo N since N is a power of two.
    // Grants are suppressed during reset so no input sees in_ready while rst is high.
    always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      gnt_oh  = '0;
      for (int k = 0; k < N; k++) begin
        idx = ptr_reg + DW'(k);
        if (!gnt_vld && req[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = idx;
        end
      end
      gnt_vld = gnt_vld && ld && !rst;
      gnt_oh[gnt_idx] = gnt_vld;
    end

    always_comb begin
      data_next  = data_reg;
      valid_next = valid_reg;
      ptr_next   = ptr_reg;
      if (ld) begin
        valid_next = gnt_vld;
        if (gnt_vld) begin
          ptr_next = gnt_idx + DW'(1);
          for (int i = 0; i < N; i++) begin
            if (gnt_oh[i]) begin
              data_next = bus.in_data[i*WIDTH +: WIDTH];
            end
          end
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        ptr_reg   <= '0;
        data_reg  <= '0;
        valid_reg <= 1'b0;
      end else begin
        ptr_reg   <= ptr_next;
        data_reg  <= data_next;
        valid_reg <= valid_next;
      end
    end

    assign bus.out_data[gi*WIDTH +: WIDTH] = data_reg;
    assign bus.out_valid[gi]               = valid_reg;
    assign gnt_mat[gi]                     = gnt_oh;
  end

  // Each input addresses exactly one output, so at most one row can grant it.
  always_comb begin
    bus.in_ready = '0;
    for (int o = 0; o < N; o++) begin
      bus.in_ready = bus.in_ready | gnt_mat[o];
    end
  end
endmodule

// File: tb/tb_crossbar_nxn_rr.sv
// Directed and random stimulus for crossbar_nxn_rr, checked against a
// transaction-level model of per-output round-robin arbitration.
module tb_crossbar_nxn_rr;
  localparam int N     = 4;
  localparam int WIDTH = 4;
  localparam int DW    = $clog2(N);

  logic clk;
  logic rst;
  int   total;
  int   bad;

  crossbar_nxn_rr_if #(.N(N), .WIDTH(WIDTH)) bus ();

  crossbar_nxn_rr #(.N(N), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: what each output register should hold and whose turn it is.
  int               m_ptr   [N];
  logic             m_valid [N];
  logic [WIDTH-1:0] m_data  [N];
  int               g_sel   [N];
  logic [WIDTH-1:0] g_data  [N];
  logic             g_ld    [N];
  logic [N-1:0]     exp_ready;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_grants();
    exp_ready = '0;
    for (int o = 0; o < N; o++) begin
      g_sel[o]  = -1;
      g_data[o] = '0;
      g_ld[o]   = !m_valid[o] || bus.out_ready[o];
      if (!rst && g_ld[o]) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr[o] + k) % N;
          if (g_sel[o] < 0 && bus.in_valid[i] && int'(bus.in_dest[i*DW +: DW]) == o) begin
            g_sel[o] = i;
          end
        end
      end
      if (g_sel[o] >= 0) begin
        exp_ready[g_sel[o]] = 1'b1;
        g_data[o] = bus.in_data[g_sel[o]*WIDTH +: WIDTH];
      end
    end
  endfunction

  function automatic void model_update();
    for (int o = 0; o < N; o++) begin
      if (rst) begin
        m_ptr[o]   = 0;
        m_valid[o] = 1'b0;
        m_data[o]  = '0;
      end else if (g_ld[o]) begin
        if (g_sel[o] >= 0) begin
          m_data[o]  = g_data[o];
          m_valid[o] = 1'b1;
          m_ptr[o]   = (g_sel[o] + 1) % N;
        end else begin
          m_valid[o] = 1'b0;
        end
      end
    end
  endfunction

  function automatic logic [N*WIDTH-1:0] exp_data_vec();
    logic [N*WIDTH-1:0] v;
    v = '0;
    for (int o = 0; o < N; o++) v[o*WIDTH +: WIDTH] = m_data[o];
    return v;
  endfunction

  function automatic logic [N-1:0] exp_valid_vec();
    logic [N-1:0] v;
    v = '0;
    for (int o = 0; o < N; o++) v[o] = m_valid[o];
    return v;
  endfunction

  // One clock: check in_ready before the edge, advance the model, check outputs after.
  task automatic step();
    #1;
    model_grants();
    check("in_ready", 64'(bus.in_ready), 64'(exp_ready));
    @(posedge clk);
    model_update();
    #1;
    check("out_valid", 64'(bus.out_valid), 64'(exp_valid_vec()));
    check("out_data", 64'(bus.out_data), 64'(exp_data_vec()));
    $display("t=%0t rst=%0b in_valid=%b in_ready=%b out_ready=%b out_valid=%b out_data=%h",
             $time, rst, bus.in_valid, exp_ready, bus.out_ready, bus.out_valid, bus.out_data);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int o = 0; o < N; o++) begin
      m_ptr[o] = 0; m_valid[o] = 1'b0; m_data[o] = '0;
    end

    // Reset held two cycles with every input requesting output 0.
    rst           = 1'b1;
    bus.in_data   = 16'h4321;
    bus.in_dest   = 8'h00;
    bus.in_valid  = 4'hF;
    bus.out_ready = 4'hF;
    step();
    step();
    check("reset_valid", 64'(bus.out_valid), 64'h0);
    check("reset_data", 64'(bus.out_data), 64'h0);
    rst = 1'b0;
    step();
    check("first_grant", 64'(bus.out_data[3:0]), 64'h1);

    // Permutation: input i to output 3-i.
    bus.in_data  = 16'hDCBA;
    bus.in_dest  = 8'h1B;
    bus.in_valid = 4'hF;
    #1 check("perm_ready", 64'(bus.in_ready), 64'hF);
    step();
    check("perm_data", 64'(bus.out_data), 64'hABCD);
    check("perm_valid", 64'(bus.out_valid), 64'hF);
    bus.in_valid = 4'h0;
    step();

    // Round-robin contention on output 2 from a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.in_data  = 16'h4321;
    bus.in_dest  = 8'hAA;
    bus.in_valid = 4'hF;
    for (int c = 0; c < N; c++) begin
      step();
      check("rr_seq", 64'(bus.out_data[11:8]), 64'(c + 1));
      bus.in_valid = bus.in_valid & ~exp_ready;
    end
    bus.in_valid = 4'b1001;
    step();
    check("rr_wrap0", 64'(bus.out_data[11:8]), 64'h1);
    bus.in_valid = bus.in_valid & ~exp_ready;
    step();
    check("rr_wrap3", 64'(bus.out_data[11:8]), 64'h4);

    // Reset mid-stream: rotation would favour input 2, reset restores input 0.
    bus.in_valid = 4'hF;
    step();
    bus.in_valid = bus.in_valid & ~exp_ready;
    step();
    bus.in_valid = 4'b1101;
    rst = 1'b1;
    step();
    check("midrst_valid", 64'(bus.out_valid), 64'h0);
    rst = 1'b0;
    #1 check("midrst_ready", 64'(bus.in_ready), 64'b0001);
    step();
    check("midrst_data", 64'(bus.out_data[11:8]), 64'h1);
    bus.in_valid = 4'h0;
    step();
    step();

    // Backpressure on output 1.
    bus.in_data   = 16'h0005;
    bus.in_dest   = 8'h01;
    bus.in_valid  = 4'b0001;
    bus.out_ready = 4'b1101;
    step();
    check("bp_load", 64'(bus.out_data[7:4]), 64'h5);
    bus.in_data  = 16'h0900;
    bus.in_dest  = 8'h10;
    bus.in_valid = 4'b0100;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_hold", 64'(bus.out_data[7:4]), 64'h5);
      check("bp_stall", 64'(bus.in_ready[2]), 64'h0);
    end
    bus.out_ready = 4'hF;
    #1 check("bp_release", 64'(bus.in_ready[2]), 64'h1);
    step();
    check("bp_next", 64'(bus.out_data[7:4]), 64'h9);
    check("bp_nobubble", 64'(bus.out_valid[1]), 64'h1);
    bus.in_valid = 4'h0;

    // Drain output 0.
    step();
    bus.in_data  = 16'h0007;
    bus.in_dest  = 8'h00;
    bus.in_valid = 4'b0001;
    step();
    check("drain_load", 64'(bus.out_valid[0]), 64'h1);
    bus.in_valid = 4'h0;
    step();
    check("drain_empty", 64'(bus.out_valid[0]), 64'h0);
    check("drain_keep", 64'(bus.out_data[3:0]), 64'h7);

    // Random traffic; stalled inputs keep their word per valid/ready rules.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(bus.in_valid[i] && !exp_ready[i])) begin
          bus.in_valid[i]               = 1'($urandom);
          bus.in_dest[i*DW +: DW]       = DW'($urandom);
          bus.in_data[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end
      end
      bus.out_ready = N'($urandom);
      rst = ($urandom_range(0, 59) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
